mul_div_seq: RTL



---
 rtl/mul_div_seq_pkg.sv | 16 +
 rtl/mul_div_seq_if.sv | 28 ++
 rtl/mul_div_seq_add_sub_w.sv | 14 +
 rtl/mul_div_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mul_div_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// FSM encoding, operation codes and the default operand width.
package mul_div_seq_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mul_div_seq_if.sv
// Request/result bundle between the ALU control (master) and the sequencer (slave).
// start is a request pulse, sampled only while the sequencer is in IDLE or DONE;
// there is no ready signal, the caller must hold off while busy is high.
// done is a one-cycle pulse, and the result fields hold until the next completion.
interface mul_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;
  logic             z;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero, z
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero, z
  );
endinterface

// File: rtl/mul_div_seq_add_sub_w.sv
// Combinational WIDTH+1-bit adder/subtractor shared by the multiply and divide steps.
// sub=1 computes x - y as x + ~y + 1, so sum[WIDTH] is the borrow indicator.
module add_sub_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  assign sum = x + (sub ? ~y : y) + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle unsigned shift-add multiplier and restoring divider, one bit per clock.
// Working registers work_hi/work_lo hold {P_hi,P_lo} for multiply and {R,Q} for divide.
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_seq_if.slave   bus,
  output state_t         dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic             op_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] res_lo_r;
  logic [WIDTH-1:0] res_hi_r;
  logic             dbz_r;
  logic             z_r;

  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic             add_sub;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  always_comb begin
    sh      = {work_hi, work_lo[WIDTH-1]};
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    if (op_r == OP_DIV) begin
      add_x   = sh;
      add_y   = {1'b0, b_r};
      add_sub = 1'b1;
    end else begin
      add_x   = {1'b0, work_hi};
      add_y   = {1'b0, (work_lo[0] ? b_r : '0)};
      add_sub = 1'b0;
    end
  end

  add_sub_w #(.WIDTH(WIDTH)) u_add_sub (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .sum (add_sum)
  );

  // Multiply: the carry-out of the partial sum shifts into the MSB of P_hi.
  // Divide: a clear borrow bit means the trial subtraction fits.
  always_comb begin
    next_hi = work_hi;
    next_lo = work_lo;
    if (op_r == OP_DIV) begin
      if (!add_sum[WIDTH]) begin
        next_hi = add_sum[WIDTH-1:0];
        next_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = sh[WIDTH-1:0];
        next_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi = add_sum[WIDTH:1];
      next_lo = {add_sum[0], work_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_r     <= OP_MUL;
      b_r      <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      res_lo_r <= '0;
      res_hi_r <= '0;
      dbz_r    <= 1'b0;
      z_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            op_r <= bus.op;
            b_r  <= bus.b;
            if (bus.op == OP_DIV && bus.b == '0) begin
              state    <= DONE;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              res_lo_r <= '1;
              res_hi_r <= bus.a;
              dbz_r    <= 1'b1;
              z_r      <= 1'b0;
            end else begin
              state   <= RUN;
              busy_r  <= 1'b1;
              count   <= '0;
              work_hi <= '0;
              work_lo <= bus.a;
            end
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          work_hi <= next_hi;
          work_lo <= next_lo;
          if (count == LAST) begin
            state    <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            res_lo_r <= next_lo;
            res_hi_r <= next_hi;
            dbz_r    <= 1'b0;
            z_r      <= (next_lo == '0);
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result_lo   = res_lo_r;
  assign bus.result_hi   = res_hi_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.z           = z_r;
  assign dbg_state       = state;

endmodule
